pwm_timer_out: RTL and testbench
================================

# pwm_timer_out

Output stage of the PWM/timer block, directly downstream of `main_counter`. It consumes the shared 16-bit `counter` together with the mode/control bits and period/duty registers. In PWM mode it produces the registered `pwm_out` waveform from a shadowed duty value. In timer mode it detects terminal count, tracks one-shot completion and raises the `irq` interrupt flag.

## Interface
- No parameters; widths are fixed at 16 bits to match `main_counter`.
- `slow_clk`  in  1  slow clock from `clk_divider`, rising-edge.
- `rst`  in  1  system reset, synchronous, active-high.
- `sw_rst`  in  1  software reset from ctrl, synchronous, active-high; same effect as `rst`.
- `counter_en`  in  1  ctrl[2], counting enabled.
- `mode`  in  1  ctrl[1]: 1 = PWM, 0 = timer.
- `timer_mode`  in  1  ctrl[3]: 1 = continuous, 0 = one-shot.
- `irq_en`  in  1  interrupt enable.
- `irq_clr`  in  1  one-cycle clear pulse for `irq`, from register-file write.
- `period_reg`  in  16  period register.
- `duty_reg`  in  16  duty register (PWM high-time in counts).
- `counter`  in  16  output of `main_counter`.
- `pwm_out`  out  1  registered PWM waveform.
- `irq`  out  1  sticky interrupt flag.
- `timer_done`  out  1  one-shot has expired (level).

## Operation
- **Reset.** `rst` or `sw_rst` high at a rising edge forces all of the following. Reset wins over every other event.
  - `pwm_out`=0, `irq`=0, `timer_done`=0.
  - `duty_sh`=0.
  - state = IDLE.
- **Duty shadow (`duty_sh`, 16 bit).**
  - Loads `duty_reg` at any edge where `counter_en`=0.
  - Loads `duty_reg` at any edge where `mode`=1 and `counter`==0, i.e. the start of each PWM period.
  - Otherwise it holds, so a mid-period `duty_reg` write takes effect at the next period.
- **PWM (`mode`=1, `counter_en`=1).**
  - `pwm_out` <= (`counter` < `duty_sh`) && (`period_reg` != 0), a 16-bit unsigned compare.
  - `duty_sh`=0 gives 0% (constant low).
  - `duty_sh` >= `period_reg` gives 100% (constant high).
- **PWM output outside PWM mode.** With `counter_en`=0 or `mode`=0, `pwm_out` <= 0.
- **Timer FSM.**
  - IDLE → RUN when `counter_en`=1 and `mode`=0.
  - RUN, match (`counter`==`period_reg`, `period_reg`!=0): set `irq` if `irq_en`.
    - `timer_mode`=1: stay in RUN.
    - `timer_mode`=0: go to DONE.
  - DONE: `timer_done`=1. No further matches are taken, although `counter` stays at 0 and `period_reg` may change.
  - Any state → IDLE when `counter_en`=0 or `mode`=1. Entering IDLE clears `timer_done`; `irq` is not cleared.
- **`irq` flag.**
  - Set by a timer match while `irq_en`=1; cleared by `irq_clr`.
  - Set and `irq_clr` in the same cycle: set wins.
  - Deasserting `irq_en` masks new sets only; it does not clear a pending flag.
- **`period_reg`=0 in timer mode.** Never matches: no `irq` and no DONE.

## Timing
- All outputs are registered. Latency is 1 `slow_clk` from the sampled `counter` to `pwm_out`, `irq` and `timer_done`.
- `pwm_out` during cycle n+1 reflects `counter` during cycle n. The waveform therefore lags `counter` by one cycle but keeps exact duty and period.
- `irq` rises on the edge after the cycle in which `counter`==`period_reg`. It falls on the edge after `irq_clr`=1, unless a set occurs in that same cycle.
- `timer_done` rises together with the one-shot `irq`.
- Synchronous reset mid-operation: outputs are 0 on the following edge. `main_counter` is reset independently; this block does not depend on that ordering.

## Configuration
- Macro: `PWM_TIMER_OUT_PWM_IRQ_EN`.
- **Defined.** In PWM mode with `counter_en`=1, `irq` also sets (gated by `irq_en`) on the edge after `counter`==`period_reg`-1. This is the end of each PWM period, and only when `period_reg`!=0.
- **Undefined.** PWM mode never sets `irq`; interrupts come from timer mode only.

## Test plan
- **Reset.** Assert `rst` for 1 cycle mid-PWM with `pwm_out`=1 → `pwm_out`, `irq`, `timer_done` all 0 after the edge; `duty_sh`=0.
- **PWM duty.** `period_reg`=4, `duty_reg`=2 → `pwm_out` = 1,1,0,0 repeating, lagging counter 0,1,2,3 by 1 cycle.
- **PWM duty extremes.** `duty_reg`=0 → constant 0. `duty_reg`=4 and then 9 → constant 1.
- **Shadow update.** With `period_reg`=8 and `duty_reg`=2, write `duty_reg`=6 at counter=3 → current period keeps 2 high cycles; next period has 6.
- **Timer continuous.** `period_reg`=4, `timer_mode`=1, `irq_en`=1 → `irq` rises after counter=4.
  - Pulse `irq_clr` → `irq` falls.
  - Next match (5 cycles later) sets `irq` again.
  - `irq_clr` coincident with a match → `irq` stays 1.
- **Timer one-shot.** `period_reg`=4, `timer_mode`=0 → `irq` and `timer_done` rise after counter=4; counter holds 0 for 5+ cycles with no further set.
  - Drop `counter_en` → `timer_done`=0 and `irq` still 1.
  - With `period_reg`=0 → never fires.

Source files
------------

// File: rtl/pwm_timer_out.sv
// pwm_timer_out: output stage of the PWM/timer block.
// Consumes the shared 16-bit counter from main_counter and produces the
// registered PWM waveform, the sticky interrupt flag and the one-shot done level.
// Optional feature macro: PWM_TIMER_OUT_PWM_IRQ_EN (adds an end-of-period irq
// in PWM mode). Without it, irq is raised by timer matches only.
module pwm_timer_out (
  input  logic        slow_clk,
  input  logic        rst,
  input  logic        sw_rst,
  input  logic        counter_en,
  input  logic        mode,
  input  logic        timer_mode,
  input  logic        irq_en,
  input  logic        irq_clr,
  input  logic [15:0] period_reg,
  input  logic [15:0] duty_reg,
  input  logic [15:0] counter,
  output logic        pwm_out,
  output logic        irq,
  output logic        timer_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] duty_sh_q;
  logic        pwm_q;
  logic        irq_q;
  logic        done_q;

  logic        any_rst;
  logic        period_nz;
  logic        pwm_active;
  logic        timer_active;
  logic        duty_load;
  logic        timer_match;
  logic        timer_set;
  logic        pwm_set;
  logic        irq_set;

  // Decode the per-cycle conditions shared by the shadow, PWM and timer logic.
  always_comb begin
    any_rst      = rst | sw_rst;
    period_nz    = (period_reg != '0);
    pwm_active   = counter_en & mode;
    timer_active = counter_en & ~mode;
    duty_load    = ~counter_en | (mode & (counter == '0));
    timer_match  = (state_q == RUN) & timer_active & period_nz & (counter == period_reg);
    timer_set    = timer_match & irq_en;
`ifdef PWM_TIMER_OUT_PWM_IRQ_EN
    pwm_set      = pwm_active & period_nz & irq_en & (counter == (period_reg - 16'd1));
`else
    pwm_set      = 1'b0;
`endif
    irq_set      = timer_set | pwm_set;
  end

  // Duty shadow: reloads while stopped or at the start of each PWM period.
  always_ff @(posedge slow_clk) begin
    if (any_rst) begin
      duty_sh_q <= '0;
    end else if (duty_load) begin
      duty_sh_q <= duty_reg;
    end
  end

  // Registered PWM compare against the shadowed duty value.
  always_ff @(posedge slow_clk) begin
    if (any_rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_active & period_nz & (counter < duty_sh_q);
    end
  end

  // Sticky interrupt flag: a set in the same cycle as a clear wins.
  always_ff @(posedge slow_clk) begin
    if (any_rst) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  // Timer FSM with registered timer_done level.
  always_ff @(posedge slow_clk) begin
    if (any_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else if (!timer_active) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
        end
        RUN: begin
          if (timer_match && !timer_mode) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out    = pwm_q;
  assign irq        = irq_q;
  assign timer_done = done_q;

endmodule

// File: tb/tb_pwm_timer_out.sv
// tb_pwm_timer_out: directed scoreboard bench for pwm_timer_out.
// Each step drives counter (and whatever control bits precede it), pushes the
// outputs expected after the next rising edge, then pops and compares #1 later.
module tb_pwm_timer_out;

  logic        slow_clk;
  logic        rst;
  logic        sw_rst;
  logic        counter_en;
  logic        mode;
  logic        timer_mode;
  logic        irq_en;
  logic        irq_clr;
  logic [15:0] period_reg;
  logic [15:0] duty_reg;
  logic [15:0] counter;
  logic        pwm_out;
  logic        irq;
  logic        timer_done;

  typedef struct packed {
    logic pwm;
    logic irq;
    logic done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total;
  int    bad;

  pwm_timer_out dut (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .counter_en (counter_en),
    .mode       (mode),
    .timer_mode (timer_mode),
    .irq_en     (irq_en),
    .irq_clr    (irq_clr),
    .period_reg (period_reg),
    .duty_reg   (duty_reg),
    .counter    (counter),
    .pwm_out    (pwm_out),
    .irq        (irq),
    .timer_done (timer_done)
  );

  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // One clock step: drive counter, expect outputs after the coming edge.
  task automatic cyc(input logic [15:0] ctr, input logic ep, input logic ei,
                     input logic ed, input string tag);
    exp_t  e;
    string t;
    counter = ctr;
    e.pwm  = ep;
    e.irq  = ei;
    e.done = ed;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge slow_clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (pwm_out === e.pwm) else begin
      bad++;
      $error("FAIL %s pwm_out got=%b want=%b", t, pwm_out, e.pwm);
    end
    total++;
    assert (irq === e.irq) else begin
      bad++;
      $error("FAIL %s irq got=%b want=%b", t, irq, e.irq);
    end
    total++;
    assert (timer_done === e.done) else begin
      bad++;
      $error("FAIL %s timer_done got=%b want=%b", t, timer_done, e.done);
    end
  endtask

  // Preload the shadow with counting stopped, then run whole PWM periods.
  task automatic pwm_run(input int unsigned duty, input int unsigned per,
                         input int unsigned nper, input string tag);
    mode       = 1'b1;
    irq_en     = 1'b0;
    period_reg = 16'(per);
    duty_reg   = 16'(duty);
    counter_en = 1'b0;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, {tag, "_load"});
    counter_en = 1'b1;
    for (int unsigned p = 0; p < nper; p++) begin
      for (int unsigned c = 0; c < per; c++) begin
        cyc(16'(c), (c < duty), 1'b0, 1'b0, tag);
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    sw_rst     = 1'b0;
    counter_en = 1'b0;
    mode       = 1'b0;
    timer_mode = 1'b0;
    irq_en     = 1'b0;
    irq_clr    = 1'b0;
    period_reg = 16'd0;
    duty_reg   = 16'd0;
    counter    = 16'd0;

    cyc(16'd0, 1'b0, 1'b0, 1'b0, "reset0");
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "reset1");
    rst = 1'b0;

    // PWM 50%: 1,1,0,0 lagging counter by one cycle.
    pwm_run(2, 4, 3, "pwm_duty2");
    // Duty extremes and zero period.
    pwm_run(0, 4, 2, "pwm_duty0");
    pwm_run(4, 4, 2, "pwm_duty4");
    pwm_run(9, 4, 2, "pwm_duty9");
    period_reg = 16'd0;
    duty_reg   = 16'd2;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "pwm_per0_a");
    cyc(16'd1, 1'b0, 1'b0, 1'b0, "pwm_per0_b");

    // Reset mid-PWM while pwm_out is high; shadow must come back as 0.
    pwm_run(2, 4, 1, "pwm_pre_rst");
    cyc(16'd0, 1'b1, 1'b0, 1'b0, "pwm_high_before_rst");
    rst = 1'b1;
    cyc(16'd1, 1'b0, 1'b0, 1'b0, "rst_mid_pwm");
    rst = 1'b0;
    cyc(16'd1, 1'b0, 1'b0, 1'b0, "rst_shadow_zero_1");
    cyc(16'd2, 1'b0, 1'b0, 1'b0, "rst_shadow_zero_2");
    cyc(16'd3, 1'b0, 1'b0, 1'b0, "rst_shadow_zero_3");
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "rst_shadow_reload");
    cyc(16'd1, 1'b1, 1'b0, 1'b0, "rst_shadow_reloaded");
    sw_rst = 1'b1;
    cyc(16'd2, 1'b0, 1'b0, 1'b0, "sw_rst_mid_pwm");
    sw_rst = 1'b0;

    // Shadow update: mid-period duty write applies from the next period.
    pwm_run(2, 8, 0, "shadow");
    cyc(16'd0, 1'b1, 1'b0, 1'b0, "shadow_c0");
    cyc(16'd1, 1'b1, 1'b0, 1'b0, "shadow_c1");
    cyc(16'd2, 1'b0, 1'b0, 1'b0, "shadow_c2");
    duty_reg = 16'd6;
    for (int unsigned c = 3; c < 8; c++) cyc(16'(c), 1'b0, 1'b0, 1'b0, "shadow_old");
    for (int unsigned c = 0; c < 8; c++) cyc(16'(c), (c < 6), 1'b0, 1'b0, "shadow_new");

    // Timer continuous, period 4: counter runs 0..4.
    mode       = 1'b0;
    timer_mode = 1'b1;
    irq_en     = 1'b1;
    period_reg = 16'd4;
    for (int unsigned c = 0; c < 4; c++) cyc(16'(c), 1'b0, 1'b0, 1'b0, "cont_pre");
    cyc(16'd4, 1'b0, 1'b1, 1'b0, "cont_match1");
    cyc(16'd0, 1'b0, 1'b1, 1'b0, "cont_hold");
    irq_clr = 1'b1;
    cyc(16'd1, 1'b0, 1'b0, 1'b0, "cont_clr");
    irq_clr = 1'b0;
    cyc(16'd2, 1'b0, 1'b0, 1'b0, "cont_after_clr2");
    cyc(16'd3, 1'b0, 1'b0, 1'b0, "cont_after_clr3");
    cyc(16'd4, 1'b0, 1'b1, 1'b0, "cont_match2");
    for (int unsigned c = 0; c < 4; c++) cyc(16'(c), 1'b0, 1'b1, 1'b0, "cont_sticky");
    irq_clr = 1'b1;
    cyc(16'd4, 1'b0, 1'b1, 1'b0, "cont_set_beats_clr");
    irq_clr = 1'b0;
    irq_en  = 1'b0;
    cyc(16'd0, 1'b0, 1'b1, 1'b0, "mask_keeps_pending0");
    cyc(16'd1, 1'b0, 1'b1, 1'b0, "mask_keeps_pending1");
    cyc(16'd2, 1'b0, 1'b1, 1'b0, "mask_keeps_pending2");
    irq_clr = 1'b1;
    cyc(16'd3, 1'b0, 1'b0, 1'b0, "mask_clr");
    irq_clr = 1'b0;
    cyc(16'd4, 1'b0, 1'b0, 1'b0, "mask_blocks_set");
    irq_en = 1'b1;

    // Timer one-shot.
    counter_en = 1'b0;
    timer_mode = 1'b0;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "os_idle");
    counter_en = 1'b1;
    for (int unsigned c = 0; c < 4; c++) cyc(16'(c), 1'b0, 1'b0, 1'b0, "os_pre");
    cyc(16'd4, 1'b0, 1'b1, 1'b1, "os_match");
    for (int unsigned c = 0; c < 6; c++) cyc(16'd0, 1'b0, 1'b1, 1'b1, "os_done_hold");
    counter_en = 1'b0;
    cyc(16'd0, 1'b0, 1'b1, 1'b0, "os_disable_keeps_irq");
    counter_en = 1'b1;
    irq_clr    = 1'b1;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "os2_clr");
    irq_clr = 1'b0;
    for (int unsigned c = 1; c < 4; c++) cyc(16'(c), 1'b0, 1'b0, 1'b0, "os2_pre");
    cyc(16'd4, 1'b0, 1'b1, 1'b1, "os2_match");
    irq_clr = 1'b1;
    cyc(16'd0, 1'b0, 1'b0, 1'b1, "os2_clr_in_done");
    irq_clr = 1'b0;
    cyc(16'd4, 1'b0, 1'b0, 1'b1, "os2_done_no_match");
    cyc(16'd0, 1'b0, 1'b0, 1'b1, "os2_done_hold");

    // Zero period never matches, in either timer mode.
    counter_en = 1'b0;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "p0_idle");
    counter_en = 1'b1;
    period_reg = 16'd0;
    for (int unsigned c = 0; c < 6; c++) cyc(16'(c % 3), 1'b0, 1'b0, 1'b0, "p0_oneshot");
    timer_mode = 1'b1;
    for (int unsigned c = 0; c < 4; c++) cyc(16'd0, 1'b0, 1'b0, 1'b0, "p0_cont");

    // Software reset clears a pending timer irq.
    period_reg = 16'd4;
    for (int unsigned c = 0; c < 4; c++) cyc(16'(c), 1'b0, 1'b0, 1'b0, "swr_pre");
    cyc(16'd4, 1'b0, 1'b1, 1'b0, "swr_match");
    sw_rst = 1'b1;
    cyc(16'd0, 1'b0, 1'b0, 1'b0, "swr_clears");
    sw_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
